// File: rtl/ask_pkg.sv
// Shared constants, FSM state encoding and output range reduction for the ASK modulator.
// Build option: define ASK_MOD_SAT_EN to clamp out-of-range products instead of wrapping.
package ask_pkg;

  localparam int CW_W_DEF = 10;
  localparam int BS_W_DEF = 3;
  localparam int SPS_DEF  = 8;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

`ifdef ASK_MOD_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Caller keeps the low out_w bits; without clamping that is a plain wrap-around.
  function automatic logic signed [63:0] fit_result(input logic signed [63:0] x,
                                                    input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    fit_result = x;
    if (SAT_EN) begin
      if (x > hi)      fit_result = hi;
      else if (x < lo) fit_result = lo;
    end
  endfunction

endpackage

// File: rtl/ask_mult_core.sv
// Two-stage sign-magnitude multiply: stage 1 holds sign and magnitudes, stage 2 the reduced product.
// Output reduction follows ASK_MOD_SAT_EN (clamp) or its absence (wrap).
module ask_mult_core
  import ask_pkg::*;
#(
  parameter int CW_W  = CW_W_DEF,
  parameter int BS_W  = BS_W_DEF,
  parameter int OUT_W = CW_W + BS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CW_W-1:0]  a,
  input  logic [BS_W-1:0]  b,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data
);

  localparam int PW = CW_W + BS_W;

  logic            v1;
  logic            sgn1;
  logic [CW_W-1:0] mag_a1;
  logic [BS_W-1:0] mag_b1;
  logic [CW_W-1:0] mag_a_c;
  logic [BS_W-1:0] mag_b_c;
  logic [PW-1:0]   prod_u;
  logic signed [PW-1:0] prod_s;

  // Negating the most negative value leaves 2^(W-1), which is the correct unsigned magnitude.
  always_comb begin
    mag_a_c = a[CW_W-1] ? -a : a;
    mag_b_c = b[BS_W-1] ? -b : b;
    prod_u  = PW'(mag_a1) * PW'(mag_b1);
    prod_s  = sgn1 ? -$signed(prod_u) : $signed(prod_u);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      sgn1      <= 1'b0;
      mag_a1    <= '0;
      mag_b1    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        sgn1   <= a[CW_W-1] ^ b[BS_W-1];
        mag_a1 <= mag_a_c;
        mag_b1 <= mag_b_c;
      end
      out_valid <= v1;
      if (v1) out_data <= OUT_W'(fit_result(64'(prod_s), OUT_W));
    end
  end

endmodule

// File: rtl/ask_mod_stream.sv
// Streaming ASK modulator: scales each carrier sample by the current symbol amplitude.
// Build option: ASK_MOD_SAT_EN selects clamping of narrowed outputs (see ask_pkg).
module ask_mod_stream
  import ask_pkg::*;
#(
  parameter int CW_W  = CW_W_DEF,
  parameter int BS_W  = BS_W_DEF,
  parameter int OUT_W = CW_W + BS_W,
  parameter int SPS   = SPS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cw_valid,
  input  logic [CW_W-1:0]  cw_data,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic [BS_W-1:0]  sym_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             sym_underrun
);

  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [BS_W-1:0] cur_sym;
  logic [BS_W-1:0] amp;
  logic            sym_end;

  // Handshake: a symbol moves when sym_valid && sym_ready; ready is high whenever idle,
  // or on the final carrier sample of the running symbol so symbols chain gap-free.
  always_comb begin
    sym_end   = (state == ST_RUN) && cw_valid && (cnt == LAST);
    sym_ready = !rst && ((state == ST_IDLE) || sym_end);
    amp       = (state == ST_RUN) ? cur_sym : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cur_sym      <= '0;
      sym_underrun <= 1'b0;
    end else begin
      sym_underrun <= 1'b0;
      if (state == ST_IDLE) begin
        if (sym_valid) begin
          cur_sym <= sym_data;
          cnt     <= '0;
          state   <= ST_RUN;
        end
      end else if (cw_valid) begin
        if (cnt == LAST) begin
          cnt <= '0;
          if (sym_valid) begin
            cur_sym <= sym_data;
          end else begin
            state        <= ST_IDLE;
            sym_underrun <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  ask_mult_core #(
    .CW_W  (CW_W),
    .BS_W  (BS_W),
    .OUT_W (OUT_W)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (cw_valid),
    .a         (cw_data),
    .b         (amp),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule
